// File: rtl/ysyx_22041207_cache_pkg.sv
// Shared types and constants for the data-cache miss-handling controller.
package ysyx_22041207_cache_pkg;

    localparam int unsigned ADDR_W_DEF  = 64;
    localparam int unsigned DATA_W_DEF  = 64;
    localparam int unsigned OFFSET_BITS = 3;

    // Clears the byte offset within an 8-byte line.
    localparam logic [63:0] ALIGN_MASK = ~64'((64'd1 << OFFSET_BITS) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MREQ,
        S_MWAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/ysyx_22041207_sat_counter.sv
// Saturating up-counter used for cache performance statistics.
module ysyx_22041207_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count up on inc, hold once all-ones is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ysyx_22041207_cache_refill.sv
// Miss-handling controller: probes the cache, refills on load miss,
// writes stores through to memory and updates the cache on store hit.
module ysyx_22041207_cache_refill
    import ysyx_22041207_cache_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    input  logic [7:0]        cpu_req_wmask,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    output logic [ADDR_W-1:0] probe_addr,
    input  logic              probe_hit,
    input  logic [DATA_W-1:0] probe_data,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              wupd_valid,
    output logic [ADDR_W-1:0] wupd_addr,
    output logic [DATA_W-1:0] wupd_data,
    output logic [7:0]        wupd_mask,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [CNT_W-1:0]  perf_hits,
    output logic [CNT_W-1:0]  perf_misses
);

    state_e            state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_al;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hit_inc, miss_inc;
    logic              go_resp;

    assign addr_al = addr_q & ADDR_W'(ALIGN_MASK);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, probe sampling, memory data capture and counter strobes.
    always_comb begin
        state_d  = state_q;
        hit_d    = hit_q;
        data_d   = data_q;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                hit_d  = probe_hit;
                data_d = probe_data;
                if (we_q) begin
                    state_d = S_MREQ;
                end else if (probe_hit) begin
                    state_d = S_RESP;
                    hit_inc = 1'b1;
                end else begin
                    state_d  = S_MREQ;
                    miss_inc = 1'b1;
                end
            end
            S_MREQ: begin
                if (mem_req_ready) state_d = S_MWAIT;
            end
            S_MWAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_RESP;
                    if (!we_q) data_d = mem_resp_data;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign go_resp = (state_d == S_RESP);

    // Request latch and working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            hit_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if ((state_q == S_IDLE) && cpu_req_valid) begin
                we_q    <= cpu_req_we;
                addr_q  <= cpu_req_addr;
                wdata_q <= cpu_req_wdata;
                wmask_q <= cpu_req_wmask;
            end
            hit_q  <= hit_d;
            data_q <= data_d;
        end
    end

    // Registered handshake, response and cache-update outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_req_ready  <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_data  <= '0;
            fill_valid     <= 1'b0;
            fill_addr      <= '0;
            fill_data      <= '0;
            wupd_valid     <= 1'b0;
            wupd_addr      <= '0;
            wupd_data      <= '0;
            wupd_mask      <= '0;
            mem_req_valid  <= 1'b0;
        end else begin
            cpu_req_ready  <= (state_d == S_IDLE);
            cpu_resp_valid <= go_resp;
            cpu_resp_data  <= (go_resp && !we_q) ? data_d : '0;
            fill_valid     <= go_resp && !we_q && !hit_d;
            fill_addr      <= (go_resp && !we_q && !hit_d) ? addr_al : '0;
            fill_data      <= (go_resp && !we_q && !hit_d) ? data_d : '0;
            wupd_valid     <= go_resp && we_q && hit_d;
            wupd_addr      <= (go_resp && we_q && hit_d) ? addr_al : '0;
            wupd_data      <= (go_resp && we_q && hit_d) ? wdata_q : '0;
            wupd_mask      <= (go_resp && we_q && hit_d) ? wmask_q : '0;
            mem_req_valid  <= (state_d == S_MREQ);
        end
    end

    // Memory payload and probe address come straight from the latched request.
    assign probe_addr    = addr_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_al;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    ysyx_22041207_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (perf_hits)
    );

    ysyx_22041207_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (perf_misses)
    );

endmodule

// File: tb/tb_ysyx_22041207_cache_refill.sv
// Directed bench for the cache miss-handling controller.
module tb_ysyx_22041207_cache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_we = 1'b0;
    logic [63:0] cpu_req_addr = '0;
    logic [63:0] cpu_req_wdata = '0;
    logic [7:0]  cpu_req_wmask = '0;
    logic        cpu_resp_valid;
    logic [63:0] cpu_resp_data;
    logic [63:0] probe_addr;
    logic        probe_hit = 1'b0;
    logic [63:0] probe_data = '0;
    logic        fill_valid;
    logic [63:0] fill_addr;
    logic [63:0] fill_data;
    logic        wupd_valid;
    logic [63:0] wupd_addr;
    logic [63:0] wupd_data;
    logic [7:0]  wupd_mask;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;

    int n_vec = 0;
    int n_err = 0;

    ysyx_22041207_cache_refill dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_req_wmask  (cpu_req_wmask),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_data  (cpu_resp_data),
        .probe_addr     (probe_addr),
        .probe_hit      (probe_hit),
        .probe_data     (probe_data),
        .fill_valid     (fill_valid),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .wupd_valid     (wupd_valid),
        .wupd_addr      (wupd_addr),
        .wupd_data      (wupd_data),
        .wupd_mask      (wupd_mask),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .perf_hits      (perf_hits),
        .perf_misses    (perf_misses)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full request, from acceptance through the cycle after RESP.
    task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, input logic hit, input logic [63:0] pdata,
                        input logic [63:0] mdata, input int bp, input logic hold,
                        input logic [63:0] addr2);
        logic [63:0] al;
        al = {addr[63:3], 3'b000};
        chk("ready_before", 64'(cpu_req_ready), 64'd1);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        cpu_req_wmask = wmask;
        cyc();
        if (hold) cpu_req_addr = addr2;
        else cpu_req_valid = 1'b0;
        probe_hit  = hit;
        probe_data = pdata;
        chk("probe_addr", probe_addr, addr);
        chk("ready_lookup", 64'(cpu_req_ready), 64'd0);
        chk("memreq_lookup", 64'(mem_req_valid), 64'd0);
        if (!we && hit) begin
            cyc();
            chk("hit_resp_valid", 64'(cpu_resp_valid), 64'd1);
            chk("hit_resp_data", cpu_resp_data, pdata);
            chk("hit_no_fill", 64'(fill_valid), 64'd0);
            chk("hit_no_memreq", 64'(mem_req_valid), 64'd0);
        end else begin
            cyc();
            for (int i = 0; i < bp; i++) begin
                chk("bp_memreq_valid", 64'(mem_req_valid), 64'd1);
                chk("bp_memreq_addr", mem_req_addr, al);
                chk("bp_ready", 64'(cpu_req_ready), 64'd0);
                chk("bp_probe_addr", probe_addr, addr);
                cyc();
            end
            chk("memreq_valid", 64'(mem_req_valid), 64'd1);
            chk("memreq_addr", mem_req_addr, al);
            chk("memreq_we", 64'(mem_req_we), 64'(we));
            if (we) begin
                chk("memreq_wmask", 64'(mem_req_wmask), 64'(wmask));
                chk("memreq_wdata", mem_req_wdata, wdata);
            end
            mem_req_ready = 1'b1;
            cyc();
            mem_req_ready = 1'b0;
            chk("mwait_memreq_off", 64'(mem_req_valid), 64'd0);
            chk("mwait_resp_off", 64'(cpu_resp_valid), 64'd0);
            cyc();
            mem_resp_valid = 1'b1;
            mem_resp_data  = mdata;
            cyc();
            mem_resp_valid = 1'b0;
            chk("resp_valid", 64'(cpu_resp_valid), 64'd1);
            chk("resp_data", cpu_resp_data, we ? 64'd0 : mdata);
            chk("ready_resp", 64'(cpu_req_ready), 64'd0);
            chk("fill_valid", 64'(fill_valid), 64'(!we));
            if (!we) begin
                chk("fill_addr", fill_addr, al);
                chk("fill_data", fill_data, mdata);
            end
            chk("wupd_valid", 64'(wupd_valid), 64'(we && hit));
            if (we && hit) begin
                chk("wupd_addr", wupd_addr, al);
                chk("wupd_data", wupd_data, wdata);
                chk("wupd_mask", 64'(wupd_mask), 64'(wmask));
            end
        end
        cyc();
        probe_hit = 1'b0;
        chk("done_resp_off", 64'(cpu_resp_valid), 64'd0);
        chk("done_fill_off", 64'(fill_valid), 64'd0);
        chk("done_wupd_off", 64'(wupd_valid), 64'd0);
        chk("done_ready", 64'(cpu_req_ready), 64'd1);
    endtask

    initial begin
        // Reset: ready low and every output zero while rst is held.
        cyc();
        cyc();
        chk("rst_ready", 64'(cpu_req_ready), 64'd0);
        chk("rst_resp_valid", 64'(cpu_resp_valid), 64'd0);
        chk("rst_resp_data", cpu_resp_data, 64'd0);
        chk("rst_memreq", 64'(mem_req_valid), 64'd0);
        chk("rst_memaddr", mem_req_addr, 64'd0);
        chk("rst_fill", 64'(fill_valid), 64'd0);
        chk("rst_wupd", 64'(wupd_valid), 64'd0);
        chk("rst_hits", 64'(perf_hits), 64'd0);
        chk("rst_misses", 64'(perf_misses), 64'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", 64'(cpu_req_ready), 64'd1);

        // Load miss, then the same load hitting.
        xact(1'b0, 64'h8000_0010, 64'd0, 8'h00, 1'b0, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0, 64'd0);
        chk("miss_cnt1", 64'(perf_misses), 64'd1);
        chk("hit_cnt0", 64'(perf_hits), 64'd0);
        xact(1'b0, 64'h8000_0010, 64'd0, 8'h00, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 0, 1'b0, 64'd0);
        chk("hit_cnt1", 64'(perf_hits), 64'd1);
        chk("miss_cnt1b", 64'(perf_misses), 64'd1);

        // Unaligned store hit, then a store miss.
        xact(1'b1, 64'h8000_0013, 64'h0000_0000_AB00_0000, 8'h08, 1'b1, 64'h1111, 64'h5555, 0, 1'b0, 64'd0);
        xact(1'b1, 64'h8000_0028, 64'h0000_00EE_0000_0000, 8'h10, 1'b0, 64'h2222, 64'h6666, 0, 1'b0, 64'd0);
        chk("store_hits", 64'(perf_hits), 64'd1);
        chk("store_misses", 64'(perf_misses), 64'd1);

        // Backpressure with a second request held pending until after RESP.
        xact(1'b0, 64'h8000_0105, 64'd0, 8'h00, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 5, 1'b1, 64'h8000_0200);
        cyc();
        cpu_req_valid = 1'b0;
        probe_hit  = 1'b1;
        probe_data = 64'h0BAD_F00D_0000_0042;
        chk("second_accepted", probe_addr, 64'h8000_0200);
        chk("second_ready", 64'(cpu_req_ready), 64'd0);
        cyc();
        chk("second_resp", 64'(cpu_resp_valid), 64'd1);
        chk("second_data", cpu_resp_data, 64'h0BAD_F00D_0000_0042);
        cyc();
        probe_hit = 1'b0;
        chk("bp_misses", 64'(perf_misses), 64'd2);
        chk("bp_hits", 64'(perf_hits), 64'd2);

        // Reset during MWAIT, with a stale memory response afterwards.
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 64'h8000_0300;
        cyc();
        cpu_req_valid = 1'b0;
        cyc();
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        cyc();
        chk("mrst_ready_low", 64'(cpu_req_ready), 64'd0);
        rst = 1'b0;
        cyc();
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_resp_valid = 1'b0;
            chk("mrst_no_resp", 64'(cpu_resp_valid), 64'd0);
            chk("mrst_no_fill", 64'(fill_valid), 64'd0);
            chk("mrst_ready", 64'(cpu_req_ready), 64'd1);
        end
        chk("mrst_hits", 64'(perf_hits), 64'd0);
        chk("mrst_misses", 64'(perf_misses), 64'd0);

        // Saturation of the miss counter.
        force dut.u_miss_cnt.count_q = 32'hFFFF_FFFE;
        cyc();
        release dut.u_miss_cnt.count_q;
        cyc();
        chk("sat_preload", 64'(perf_misses), 64'h0000_0000_FFFF_FFFE);
        xact(1'b0, 64'h8000_0400, 64'd0, 8'h00, 1'b0, 64'd0, 64'h1, 0, 1'b0, 64'd0);
        chk("sat_first", 64'(perf_misses), 64'h0000_0000_FFFF_FFFF);
        xact(1'b0, 64'h8000_0408, 64'd0, 8'h00, 1'b0, 64'd0, 64'h2, 0, 1'b0, 64'd0);
        xact(1'b0, 64'h8000_0410, 64'd0, 8'h00, 1'b0, 64'd0, 64'h3, 0, 1'b0, 64'd0);
        chk("sat_hold", 64'(perf_misses), 64'h0000_0000_FFFF_FFFF);
        chk("sat_hits", 64'(perf_hits), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_22041207_cache_refill.md
# ysyx_22041207_cache_refill

Miss-handling controller in front of the 2-way, 4-set, 8-byte-line data cache. Accepts one CPU load/store at a time, probes the cache, and on a read miss fetches the word from memory and drives the cache fill port. Stores are written through to memory, and the cache is updated only when the store hits. Sits between the LSU and the memory bus arbiter, and owns all cache update strobes.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data/line width; fixed at 64
- CNT_W, 32, width of performance counters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req_valid  in  1  request valid
- cpu_req_ready  out  1  high only in IDLE
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  ADDR_W  byte address
- cpu_req_wdata  in  DATA_W  store data, already lane-aligned
- cpu_req_wmask  in  8  store byte mask
- cpu_resp_valid  out  1  one-cycle completion pulse; no backpressure
- cpu_resp_data  out  DATA_W  full 64-bit word for loads, 0 for stores
- probe_addr  out  ADDR_W  latched request address, to cache lookup
- probe_hit  in  1  cache hit, combinational from probe_addr
- probe_data  in  DATA_W  cache read data
- fill_valid  out  1  cache read-fill strobe
- fill_addr  out  ADDR_W  fill address, low 3 bits zero
- fill_data  out  DATA_W  fill data
- wupd_valid, wupd_addr, wupd_data, wupd_mask  out  1/ADDR_W/DATA_W/8  cache store-update strobe and payload
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask  out  1/ADDR_W/DATA_W/8  memory request payload; address 8-byte aligned
- mem_resp_valid  in  1  memory response, one cycle
- mem_resp_data  in  DATA_W  read data; ignored for writes
- perf_hits, perf_misses  out  CNT_W  load hit/miss counts, saturating

## Operation
- **States:** IDLE, LOOKUP, MREQ, MWAIT, RESP.
- **IDLE:**
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch we/addr/wdata/wmask and go to LOOKUP.
- **LOOKUP:** sample probe_hit and probe_data into a hit flag and a data register.
  - Load hit: go to RESP; perf_hits++.
  - Load miss: go to MREQ; perf_misses++.
  - Store: go to MREQ regardless of hit; hit flag kept.
- **MREQ:**
  - mem_req_valid = 1; payload constant until mem_req_ready.
  - mem_req_addr = addr with [2:0] cleared.
  - On ready, go to MWAIT.
- **MWAIT:**
  - On mem_resp_valid, capture mem_resp_data for loads and go to RESP.
  - mem_resp_valid is never legal in the same cycle as the mem_req handshake. Any such pulse is ignored.
- **RESP:** lasts one cycle, then returns to IDLE. cpu_resp_valid = 1.
  - Load miss: fill_valid = 1, fill_addr = aligned address, fill_data = captured word; cpu_resp_data = same word.
  - Load hit: cpu_resp_data = probe word; no fill.
  - Store hit: wupd_valid = 1 with latched aligned address, wdata and wmask.
  - Store miss: no cache update (no write-allocate).
- **Counters:** perf_* stop at all-ones. Stores are never counted.

## Timing
- **Reset:**
  - State goes to IDLE.
  - cpu_req_ready = 1 the cycle after rst deasserts; 0 while rst is high.
  - All valid outputs, perf counters and cpu_resp_data are 0.
  - Address and data outputs are 0.
- **Latency:**
  - Load hit: request accepted on edge E, LOOKUP in E+1, cpu_resp_valid in E+2.
  - Miss or store: cpu_resp_valid one cycle after the mem_resp_valid cycle.
- Back-to-back: the next request can be accepted the cycle after RESP. Peak throughput for hits is one request per 3 cycles.
- cpu_req_valid outside IDLE is ignored; the requester holds it.
- **Reset mid-operation:** any state returns to IDLE and the transaction is dropped. A late mem_resp_valid arriving in IDLE is ignored, with no fill and no response.
- fill_valid and wupd_valid are never asserted together and never outside RESP.

## Structure
- **Package ysyx_22041207_cache_pkg:**
  - State enum.
  - OFFSET_BITS = 3 and the alignment mask.
  - ADDR_W and DATA_W defaults.
- **Sub-module ysyx_22041207_sat_counter:** CNT_W parameter; inc input; synchronous clear on rst; holds at all-ones. Instantiated twice.
- All datapath registers live in the controller. No memory arrays.

## Test plan
- **Load miss then hit, latency 3 from mem handshake.**
  - Load 0x80000010, probe_hit = 0, memory returns 0xDEADBEEF_CAFEF00D after 3 cycles.
  - Required: fill_valid with fill_addr 0x80000010 and that data; cpu_resp_data equal to it.
  - Then the same load with probe_hit = 1: cpu_resp_valid at E+2 and no mem_req.
  - perf_hits = 1, perf_misses = 1.
- **Unaligned store, hit.**
  - Store 0x80000013, wmask 0x08, hit.
  - Required: mem_req_addr 0x80000010, we = 1, mask 0x08; after the response, wupd_valid with the same address and mask; cpu_resp_data 0.
- **Store miss.** Required: mem write issued, wupd_valid and fill_valid both stay 0, perf counters unchanged.
- **Backpressure.**
  - mem_req_ready low for 5 cycles.
  - Required: mem_req_valid and payload stable all 5 cycles; cpu_req_ready 0 throughout; a second cpu_req_valid is not accepted until after RESP.
- **Reset mid-MWAIT.**
  - Assert rst during MWAIT; memory response arrives 2 cycles after rst deasserts.
  - Required: no cpu_resp_valid, no fill_valid, counters 0, cpu_req_ready 1.
- **Saturation.**
  - Preload perf_misses to 2^32-2 via a forced counter and issue 3 misses.
  - Required: the count reads 0xFFFFFFFF and holds.
